mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences RV32I load/store instructions from the ALU stage onto a single-beat request/acknowledge data-memory bus. Stalls the pipeline while an access is outstanding and generates byte strobes and store-lane alignment. Extracts and extends load data, and flags misaligned accesses and bus timeouts. Sits between the ALU-stage outputs and the MEM/WB pipeline register.

Parameters:
TIMEOUT_CYCLES, 255, cycles in REQ without MEM_ACK before aborting with BUS_ERR (1..65535)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
A_VALID  in  1  ALU-stage instruction valid
A_INST  in  32  ALU-stage instruction (opcode [6:0], funct3 [14:12] used)
A_ADDR  in  32  effective address from ALU
A_STORE_DATA  in  32  rs2 value for stores
STALL  out  1  hold ALU stage and upstream
MEM_REQ  out  1  bus request, held until ACK/timeout
MEM_WE  out  1  1 = store
MEM_ADDR  out  32  word-aligned address ({addr[31:2],2'b00})
MEM_STRB  out  4  byte-lane enables
MEM_WDATA  out  32  lane-aligned store data
MEM_ACK  in  1  bus completion, 1-cycle pulse
MEM_RDATA  in  32  read word, valid with MEM_ACK
LOAD_VALID  out  1  LOAD_DATA valid (1-cycle pulse)
LOAD_DATA  out  32  extended load result
MISALIGN  out  1  misaligned access detected (1-cycle)
BUS_ERR  out  1  access aborted by timeout (1-cycle)

Behaviour:
- While RST=0: state IDLE, counter 0, and all outputs 0, including combinational ones (gated by RST).
- Memory op decode: opcode 0000011 = load, 0100011 = store. A load with funct3 in {011,110,111} or a store with funct3 > 010 is treated as a non-memory op: no action, no stall.
- Alignment: half-word needs addr[0]=0; word needs addr[1:0]=00.
- States: IDLE, REQ, DONE, ERR (encoded in the package).
- IDLE, aligned mem op with A_VALID=1:
  - STALL=1 combinationally in that cycle.
  - Register addr, funct3, WE, strobe and wdata; go to REQ.
- IDLE, misaligned mem op: MISALIGN=1 combinationally in that cycle, STALL=0, no bus access, stay in IDLE.
- IDLE, non-mem op or A_VALID=0: all outputs 0.
- REQ:
  - MEM_REQ=1, STALL=1; bus outputs come from registers and are stable.
  - Counter increments each cycle.
  - MEM_ACK=1: capture MEM_RDATA and go to DONE. ACK wins over timeout in the same cycle.
  - Counter reaches TIMEOUT_CYCLES-1 without ACK: go to ERR.
- DONE: STALL=0, MEM_REQ=0, LOAD_VALID=1 for loads only; A_* inputs ignored. Next state IDLE.
  - Re-issue is prevented: the stalled instruction is still on A_* in this cycle.
- ERR: STALL=0, BUS_ERR=1, LOAD_VALID=0, LOAD_DATA=0. Next state IDLE.
- Latency: mem op first seen at cycle t; MEM_REQ high from t+1; ACK at t+1+k (k≥0); LOAD_VALID and STALL release at t+2+k. Minimum 3 stalled-or-done cycles.
- Strobes and store data:
  - SB: STRB = 0001<<addr[1:0]; WDATA = byte replicated x4.
  - SH: STRB = 0011<<{addr[1],1'b0}; WDATA = half replicated x2.
  - SW: STRB = 1111; WDATA = data.
  - Loads: STRB = 1111, WDATA = 0.
- Load extract uses the registered addr[1:0]:
  - LB and LH: sign-extend the selected byte or half.
  - LBU and LHU: zero-extend.
  - LW: pass the word.
- LOAD_DATA = 0 whenever LOAD_VALID = 0.
- MEM_ACK in IDLE, DONE or ERR is ignored.
- Reset mid-REQ: MEM_REQ drops asynchronously and the transaction is abandoned. A late ACK after reset is ignored.
- Counter is 16-bit; it clears on entry to REQ and never wraps, since ERR fires first.

Decomposition:
- cpu_pkg holds:
  - opcode constants OP_LOAD and OP_STORE
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state encoding ST_IDLE, ST_REQ, ST_DONE, ST_ERR
- One combinational sub-module, mem_lane_align: store strobe/data alignment plus load byte/half select and extension. The FSM and counter stay in mem_access_ctrl.

Test Plan:
- LW at addr 0x0000_1004, ACK after 2 REQ cycles, RDATA 0xDEAD_BEEF → MEM_ADDR 0x1004, STRB 1111, STALL high 4 cycles, LOAD_VALID with 0xDEAD_BEEF, single MEM_REQ burst.
- LB at 0x...03, RDATA 0x80_12_34_56 → LOAD_DATA 0xFFFF_FF80; LBU same → 0x0000_0080; LH at 0x...02, RDATA 0x8001_0000 → 0xFFFF_8001.
- SB at 0x...01, data 0x1122_33AB → MEM_WE=1, STRB 0010, WDATA 0xABAB_ABAB, LOAD_VALID stays 0; SH at 0x...02, data 0x0000_BEEF → STRB 1100, WDATA 0xBEEF_BEEF.
- LW at 0x...02 → MISALIGN pulse same cycle, STALL 0, MEM_REQ never asserted.
- TIMEOUT_CYCLES=8, no ACK → MEM_REQ high exactly 8 cycles, then BUS_ERR pulse, STALL released; ACK on 8th cycle → DONE, no BUS_ERR.
- RST low during REQ → MEM_REQ/STALL drop immediately; ACK pulse 2 cycles after release → no LOAD_VALID; back-to-back loads each issue exactly one request.

Source files
------------

// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings for the load/store path. It holds the RV32I
//               opcodes and funct3 access sizes, and the state encoding of the
//               memory access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // funct3 access sizes (inst[14:12]). Bits [1:0] give the size, and bit 2
    // marks an unsigned load.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Controller state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_DONE = 2'd2;
    localparam state_t ST_ERR  = 2'd3;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_if
// Description : Bundles the ALU-stage inputs, the data-memory request/ack
//               bus and the load-result outputs of the memory access
//               controller.
//               master : the controller itself. It drives the bus request,
//                        STALL, and the load and error flags.
//               slave  : the surrounding pipeline and memory. They drive the
//                        A_* inputs, MEM_ACK and MEM_RDATA.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;

    // ALU stage -> controller
    logic        A_VALID;
    logic [31:0] A_INST;
    logic [31:0] A_ADDR;
    logic [31:0] A_STORE_DATA;
    // Controller -> pipeline
    logic        STALL;
    // Data-memory bus
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [3:0]  MEM_STRB;
    logic [31:0] MEM_WDATA;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    // Results toward MEM/WB
    logic        LOAD_VALID;
    logic [31:0] LOAD_DATA;
    logic        MISALIGN;
    logic        BUS_ERR;

    modport master (
        input  A_VALID, A_INST, A_ADDR, A_STORE_DATA, MEM_ACK, MEM_RDATA,
        output STALL, MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA,
               LOAD_VALID, LOAD_DATA, MISALIGN, BUS_ERR
    );

    modport slave (
        output A_VALID, A_INST, A_ADDR, A_STORE_DATA, MEM_ACK, MEM_RDATA,
        input  STALL, MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA,
               LOAD_VALID, LOAD_DATA, MISALIGN, BUS_ERR
    );

endinterface : mem_access_ctrl_if
`default_nettype wire

// File: rtl/mem_access_ctrl_lane_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Purely combinational byte-lane logic.
//               Store side : builds the strobe and the lane-replicated write
//                            data from the size and the address low bits.
//               Load side  : selects the byte or half-word from the returned
//                            word and applies sign or zero extension.
// Ports       : i_st_is_store/i_st_f3/i_st_addr_lo/i_st_data -> o_st_strb,
//               o_st_wdata
//               i_ld_f3/i_ld_addr_lo/i_ld_word -> o_ld_data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import cpu_pkg::*;
(
    input  logic        i_st_is_store,
    input  logic [2:0]  i_st_f3,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_strb,
    output logic [31:0] o_st_wdata,
    input  logic [2:0]  i_ld_f3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store alignment. Loads read the whole word, so they use all four
    // lanes and carry no write data.
    always_comb begin
        o_st_strb  = 4'b1111;
        o_st_wdata = 32'h0;
        if (i_st_is_store) begin
            case (i_st_f3)
                F3_B: begin
                    o_st_strb  = 4'b0001 << i_st_addr_lo;
                    o_st_wdata = {4{i_st_data[7:0]}};
                end
                F3_H: begin
                    o_st_strb  = 4'b0011 << {i_st_addr_lo[1], 1'b0};
                    o_st_wdata = {2{i_st_data[15:0]}};
                end
                default: begin
                    o_st_strb  = 4'b1111;
                    o_st_wdata = i_st_data;
                end
            endcase
        end
    end

    // Load extraction
    always_comb begin
        w_byte = 8'h00;
        case (i_ld_addr_lo)
            2'd0:    w_byte = i_ld_word[7:0];
            2'd1:    w_byte = i_ld_word[15:8];
            2'd2:    w_byte = i_ld_word[23:16];
            default: w_byte = i_ld_word[31:24];
        endcase
        w_half = i_ld_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];

        case (i_ld_f3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {24'h0, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {16'h0, w_half};
            default: o_ld_data = i_ld_word;
        endcase
    end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Sequences RV32I loads and stores from the ALU stage onto a
//               single-beat request/ack data bus. It stalls the pipeline while
//               an access is in flight and aligns the store lanes. It also
//               extends load data and flags misaligned accesses and bus
//               timeouts.
// Ports       : CLK  - clock, rising edge
//               RST  - asynchronous active-low reset
//               bus  - mem_access_ctrl_if.master (ALU inputs, memory bus,
//                      STALL, LOAD_VALID/LOAD_DATA, MISALIGN, BUS_ERR)
// Parameters  : TIMEOUT_CYCLES - REQ cycles without MEM_ACK before abort
//                                (1..65535)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    mem_access_ctrl_if.master        bus
);

    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [31:0] r_addr;
    logic [2:0]  r_f3;
    logic        r_we;
    logic [3:0]  r_strb;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_mem_op;
    logic        w_misalign;
    logic        w_idle;
    logic        w_in_req;
    logic        w_issue;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;
    logic        w_load_valid;
    logic        w_bus_on;
    logic        w_unused;

    // ------------------------------------------------------------------
    // Decode. Unsupported load widths (011, 11x) and store widths above
    // word fall through as non-memory ops.
    // ------------------------------------------------------------------
    assign w_opcode   = bus.A_INST[6:0];
    assign w_f3       = bus.A_INST[14:12];
    assign w_is_load  = (w_opcode == OP_LOAD) &&
                        (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
    assign w_is_store = (w_opcode == OP_STORE) && (w_f3 <= F3_W);
    assign w_mem_op   = bus.A_VALID && (w_is_load || w_is_store);

    // f3[1:0] is the access size for both loads and stores
    assign w_misalign = ((w_f3[1:0] == 2'b01) && bus.A_ADDR[0]) ||
                        ((w_f3[1:0] == 2'b10) && (bus.A_ADDR[1:0] != 2'b00));

    assign w_idle   = (r_state == ST_IDLE);
    assign w_in_req = (r_state == ST_REQ);
    assign w_issue  = w_idle && w_mem_op && !w_misalign;

    mem_lane_align u_lane_align (
        .i_st_is_store (w_is_store),
        .i_st_f3       (w_f3),
        .i_st_addr_lo  (bus.A_ADDR[1:0]),
        .i_st_data     (bus.A_STORE_DATA),
        .o_st_strb     (w_strb),
        .o_st_wdata    (w_wdata),
        .i_ld_f3       (r_f3),
        .i_ld_addr_lo  (r_addr[1:0]),
        .i_ld_word     (r_rdata),
        .o_ld_data     (w_ld_data)
    );

    // ------------------------------------------------------------------
    // Control FSM and timeout counter. DONE and ERR last one cycle each.
    // The stalled instruction is still on A_* during DONE, so DONE never
    // samples A_*. That is what keeps the access from being issued twice.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'h0;
            r_addr  <= 32'h0;
            r_f3    <= 3'b000;
            r_we    <= 1'b0;
            r_strb  <= 4'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state <= ST_REQ;
                        r_cnt   <= 16'h0;
                        r_addr  <= bus.A_ADDR;
                        r_f3    <= w_f3;
                        r_we    <= w_is_store;
                        r_strb  <= w_strb;
                        r_wdata <= w_wdata;
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + 16'd1;
                    // An ACK in the final counted cycle still completes
                    if (bus.MEM_ACK) begin
                        r_rdata <= bus.MEM_RDATA;
                        r_state <= ST_DONE;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_state <= ST_ERR;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Every output is gated by RST so that the combinational
    // paths from A_* are also quiet while the block is in reset.
    // ------------------------------------------------------------------
    assign w_bus_on     = RST && w_in_req;
    assign w_load_valid = RST && (r_state == ST_DONE) && !r_we;

    assign bus.STALL      = RST && (w_issue || w_in_req);
    assign bus.MISALIGN   = RST && w_idle && w_mem_op && w_misalign;
    assign bus.MEM_REQ    = w_bus_on;
    assign bus.MEM_WE     = w_bus_on && r_we;
    assign bus.MEM_ADDR   = w_bus_on ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bus.MEM_STRB   = w_bus_on ? r_strb : 4'h0;
    assign bus.MEM_WDATA  = w_bus_on ? r_wdata : 32'h0;
    assign bus.LOAD_VALID = w_load_valid;
    assign bus.LOAD_DATA  = w_load_valid ? w_ld_data : 32'h0;
    assign bus.BUS_ERR    = RST && (r_state == ST_ERR);

    // Instruction fields outside opcode/funct3 are not needed here
    assign w_unused = &{1'b0, bus.A_INST[31:15], bus.A_INST[11:7]};

endmodule : mem_access_ctrl
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed self-checking bench for mem_access_ctrl, built with
//               TIMEOUT_CYCLES = 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam int NOACK = 1000;

    logic CLK;
    logic RST;
    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int total    = 0;

    // Per-operation observations filled in by run_op
    int          stall_cnt, req_cnt, lv_cnt, err_cnt, mis_cnt;
    logic        mis_first, unstable, cap_we;
    logic [31:0] ld_val, cap_addr, cap_wdata;
    logic [3:0]  cap_strb;

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd0, op};
    endfunction

    // Present one instruction and run ncyc cycles. The instruction is held
    // until STALL is seen low. MEM_ACK is pulsed in REQ cycle number k+1.
    task automatic run_op(input logic [31:0] inst, input logic [31:0] addr,
                          input logic [31:0] sdata, input int k,
                          input logic [31:0] rdata, input int ncyc);
        logic released;
        released  = 1'b0;
        stall_cnt = 0; req_cnt = 0; lv_cnt = 0; err_cnt = 0; mis_cnt = 0;
        mis_first = 1'b0; unstable = 1'b0; ld_val = 32'h0;
        cap_addr = 32'h0; cap_wdata = 32'h0; cap_strb = 4'h0; cap_we = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge CLK); #1;
            bus.MEM_ACK = 1'b0;
            if (i == 0) begin
                bus.A_VALID = 1'b1; bus.A_INST = inst;
                bus.A_ADDR = addr;  bus.A_STORE_DATA = sdata;
            end else if (released) begin
                bus.A_VALID = 1'b0;
            end
            #1;
            if (bus.STALL) stall_cnt++;
            else released = 1'b1;
            if (bus.MISALIGN) begin
                mis_cnt++;
                if (i == 0) mis_first = 1'b1;
            end
            if (bus.LOAD_VALID) begin lv_cnt++; ld_val = bus.LOAD_DATA; end
            if (bus.BUS_ERR) err_cnt++;
            if (bus.MEM_REQ) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    cap_addr = bus.MEM_ADDR; cap_strb = bus.MEM_STRB;
                    cap_wdata = bus.MEM_WDATA; cap_we = bus.MEM_WE;
                end else if (bus.MEM_ADDR !== cap_addr || bus.MEM_STRB !== cap_strb ||
                             bus.MEM_WDATA !== cap_wdata || bus.MEM_WE !== cap_we) begin
                    unstable = 1'b1;
                end
                if (req_cnt == k + 1) begin
                    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = rdata;
                end
            end
        end
        @(posedge CLK); #1;
        bus.MEM_ACK = 1'b0; bus.A_VALID = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        RST = 1'b0;
        bus.A_VALID = 1'b1; bus.A_INST = mk(3'b010, LD); bus.A_ADDR = 32'h1000;
        @(posedge CLK); #2;
        total++;
        if (bus.STALL !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.STALL);
        else pass_cnt++;
        outs = {bus.MEM_REQ, bus.MEM_WE, bus.LOAD_VALID, bus.MISALIGN, bus.BUS_ERR,
                bus.MEM_ADDR[26:0] | bus.MEM_WDATA[26:0] | bus.LOAD_DATA[26:0] |
                {23'd0, bus.MEM_STRB}};
        total++;
        if (outs !== 32'h0) $display("FAIL reset_outputs: got %h want 00000000", outs);
        else pass_cnt++;
        bus.A_ADDR = 32'h1002;  // misaligned LW while in reset
        #1;
        total++;
        if (bus.MISALIGN !== 1'b0) $display("FAIL reset_misalign: got %b want 0", bus.MISALIGN);
        else pass_cnt++;
        bus.A_VALID = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
    endtask

    task automatic test_lw();
        run_op(mk(3'b010, LD), 32'h0000_1004, 32'h0, 2, 32'hDEAD_BEEF, 8);
        total++;
        if (cap_addr !== 32'h0000_1004) $display("FAIL lw_addr: got %h want 00001004", cap_addr);
        else pass_cnt++;
        total++;
        if (cap_strb !== 4'b1111 || cap_we !== 1'b0)
            $display("FAIL lw_strb_we: got %b/%b want 1111/0", cap_strb, cap_we);
        else pass_cnt++;
        total++;
        if (stall_cnt != 4) $display("FAIL lw_stall_cycles: got %0d want 4", stall_cnt);
        else pass_cnt++;
        total++;
        if (req_cnt != 3 || unstable !== 1'b0)
            $display("FAIL lw_req: got %0d cycles unstable=%b want 3/0", req_cnt, unstable);
        else pass_cnt++;
        total++;
        if (lv_cnt != 1 || ld_val !== 32'hDEAD_BEEF)
            $display("FAIL lw_load: got %0d x %h want 1 x deadbeef", lv_cnt, ld_val);
        else pass_cnt++;
    endtask

    task automatic test_load_extend();
        run_op(mk(3'b000, LD), 32'h0000_2003, 32'h0, 0, 32'h8012_3456, 6);
        total++;
        if (ld_val !== 32'hFFFF_FF80 || lv_cnt != 1)
            $display("FAIL lb: got %h (%0d) want ffffff80", ld_val, lv_cnt);
        else pass_cnt++;
        total++;
        if (cap_addr !== 32'h0000_2000 || stall_cnt != 2)
            $display("FAIL lb_addr_stall: got %h/%0d want 00002000/2", cap_addr, stall_cnt);
        else pass_cnt++;
        run_op(mk(3'b100, LD), 32'h0000_2003, 32'h0, 0, 32'h8012_3456, 6);
        total++;
        if (ld_val !== 32'h0000_0080) $display("FAIL lbu: got %h want 00000080", ld_val);
        else pass_cnt++;
        run_op(mk(3'b001, LD), 32'h0000_2002, 32'h0, 0, 32'h8001_0000, 6);
        total++;
        if (ld_val !== 32'hFFFF_8001) $display("FAIL lh: got %h want ffff8001", ld_val);
        else pass_cnt++;
        run_op(mk(3'b101, LD), 32'h0000_2002, 32'h0, 1, 32'h8001_0000, 6);
        total++;
        if (ld_val !== 32'h0000_8001) $display("FAIL lhu: got %h want 00008001", ld_val);
        else pass_cnt++;
        run_op(mk(3'b000, LD), 32'h0000_2001, 32'h0, 0, 32'h0000_7F00, 6);
        total++;
        if (ld_val !== 32'h0000_007F) $display("FAIL lb_pos: got %h want 0000007f", ld_val);
        else pass_cnt++;
    endtask

    task automatic test_stores();
        run_op(mk(3'b000, ST), 32'h0000_3001, 32'h1122_33AB, 0, 32'h0, 6);
        total++;
        if (cap_we !== 1'b1 || cap_strb !== 4'b0010 || cap_wdata !== 32'hABAB_ABAB)
            $display("FAIL sb: got we=%b strb=%b wdata=%h want 1/0010/abababab",
                     cap_we, cap_strb, cap_wdata);
        else pass_cnt++;
        total++;
        if (lv_cnt != 0 || cap_addr !== 32'h0000_3000)
            $display("FAIL sb_lv_addr: got %0d/%h want 0/00003000", lv_cnt, cap_addr);
        else pass_cnt++;
        run_op(mk(3'b001, ST), 32'h0000_3002, 32'h0000_BEEF, 0, 32'h0, 6);
        total++;
        if (cap_strb !== 4'b1100 || cap_wdata !== 32'hBEEF_BEEF)
            $display("FAIL sh: got strb=%b wdata=%h want 1100/beefbeef", cap_strb, cap_wdata);
        else pass_cnt++;
        run_op(mk(3'b010, ST), 32'h0000_3008, 32'hCAFE_F00D, 1, 32'h0, 6);
        total++;
        if (cap_strb !== 4'b1111 || cap_wdata !== 32'hCAFE_F00D || lv_cnt != 0)
            $display("FAIL sw: got strb=%b wdata=%h lv=%0d want 1111/cafef00d/0",
                     cap_strb, cap_wdata, lv_cnt);
        else pass_cnt++;
    endtask

    task automatic test_misalign();
        run_op(mk(3'b010, LD), 32'h0000_4002, 32'h0, 0, 32'h0, 4);
        total++;
        if (mis_first !== 1'b1 || mis_cnt != 1)
            $display("FAIL lw_misalign: got first=%b count=%0d want 1/1", mis_first, mis_cnt);
        else pass_cnt++;
        total++;
        if (stall_cnt != 0 || req_cnt != 0)
            $display("FAIL lw_misalign_bus: got stall=%0d req=%0d want 0/0", stall_cnt, req_cnt);
        else pass_cnt++;
        run_op(mk(3'b001, ST), 32'h0000_4001, 32'h0, 0, 32'h0, 4);
        total++;
        if (mis_cnt != 1 || req_cnt != 0 || stall_cnt != 0)
            $display("FAIL sh_misalign: got mis=%0d req=%0d stall=%0d want 1/0/0",
                     mis_cnt, req_cnt, stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_non_mem();
        run_op(mk(3'b011, LD), 32'h0000_6000, 32'h0, 0, 32'h0, 4);
        total++;
        if (stall_cnt + req_cnt + mis_cnt != 0)
            $display("FAIL ld_f3_011: got activity %0d want 0", stall_cnt + req_cnt + mis_cnt);
        else pass_cnt++;
        run_op(mk(3'b011, ST), 32'h0000_6001, 32'h0, 0, 32'h0, 4);
        total++;
        if (stall_cnt + req_cnt + mis_cnt != 0)
            $display("FAIL st_f3_011: got activity %0d want 0", stall_cnt + req_cnt + mis_cnt);
        else pass_cnt++;
        run_op(mk(3'b010, 7'b0110011), 32'h0000_6002, 32'h0, 0, 32'h0, 4);
        total++;
        if (stall_cnt + req_cnt + mis_cnt != 0)
            $display("FAIL alu_op: got activity %0d want 0", stall_cnt + req_cnt + mis_cnt);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        run_op(mk(3'b010, LD), 32'h0000_7000, 32'h0, NOACK, 32'h0, 14);
        total++;
        if (req_cnt != 8) $display("FAIL timeout_req_cycles: got %0d want 8", req_cnt);
        else pass_cnt++;
        total++;
        if (err_cnt != 1 || lv_cnt != 0)
            $display("FAIL timeout_bus_err: got err=%0d lv=%0d want 1/0", err_cnt, lv_cnt);
        else pass_cnt++;
        total++;
        if (stall_cnt != 9) $display("FAIL timeout_stall: got %0d want 9", stall_cnt);
        else pass_cnt++;
        run_op(mk(3'b010, LD), 32'h0000_7004, 32'h0, 7, 32'h1234_5678, 14);
        total++;
        if (req_cnt != 8 || err_cnt != 0 || lv_cnt != 1 || ld_val !== 32'h1234_5678)
            $display("FAIL ack_last_cycle: got req=%0d err=%0d lv=%0d data=%h want 8/0/1/12345678",
                     req_cnt, err_cnt, lv_cnt, ld_val);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_req();
        int late_lv, late_req;
        late_lv = 0; late_req = 0;
        @(posedge CLK); #1;
        bus.A_VALID = 1'b1; bus.A_INST = mk(3'b010, LD); bus.A_ADDR = 32'h0000_8000;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        total++;
        if (bus.MEM_REQ !== 1'b1) $display("FAIL midreset_pre_req: got %b want 1", bus.MEM_REQ);
        else pass_cnt++;
        RST = 1'b0;
        #1;
        total++;
        if (bus.MEM_REQ !== 1'b0 || bus.STALL !== 1'b0)
            $display("FAIL midreset_drop: got req=%b stall=%b want 0/0", bus.MEM_REQ, bus.STALL);
        else pass_cnt++;
        bus.A_VALID = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            bus.MEM_ACK = 1'b0;
            #1;
            if (bus.LOAD_VALID) late_lv++;
            if (bus.MEM_REQ) late_req++;
        end
        total++;
        if (late_lv != 0 || late_req != 0)
            $display("FAIL late_ack: got lv=%0d req=%0d want 0/0", late_lv, late_req);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int          phase, bursts, req_cyc, lv;
        logic        prev_req;
        logic [31:0] lvd [2];
        phase = 0; bursts = 0; req_cyc = 0; lv = 0; prev_req = 1'b0;
        lvd[0] = 32'h0; lvd[1] = 32'h0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            bus.MEM_ACK = 1'b0;
            bus.A_INST = mk(3'b010, LD);
            if (phase == 0) begin bus.A_VALID = 1'b1; bus.A_ADDR = 32'h0000_5000; end
            else if (phase == 1) begin bus.A_VALID = 1'b1; bus.A_ADDR = 32'h0000_5004; end
            else bus.A_VALID = 1'b0;
            #1;
            if (bus.MEM_REQ) begin
                req_cyc++;
                if (!prev_req) bursts++;
                bus.MEM_ACK = 1'b1;
                bus.MEM_RDATA = (bus.MEM_ADDR == 32'h0000_5000) ? 32'h1111_0000 : 32'h2222_0000;
            end
            prev_req = bus.MEM_REQ;
            if (bus.LOAD_VALID) begin
                if (lv < 2) lvd[lv] = bus.LOAD_DATA;
                lv++;
                phase++;
            end
        end
        @(posedge CLK); #1;
        bus.MEM_ACK = 1'b0; bus.A_VALID = 1'b0;
        total++;
        if (bursts != 2 || req_cyc != 2)
            $display("FAIL b2b_requests: got bursts=%0d cycles=%0d want 2/2", bursts, req_cyc);
        else pass_cnt++;
        total++;
        if (lv != 2 || lvd[0] !== 32'h1111_0000 || lvd[1] !== 32'h2222_0000)
            $display("FAIL b2b_loads: got %0d (%h,%h) want 2 (11110000,22220000)",
                     lv, lvd[0], lvd[1]);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0;
        bus.A_VALID = 1'b0; bus.A_INST = 32'h0; bus.A_ADDR = 32'h0;
        bus.A_STORE_DATA = 32'h0; bus.MEM_ACK = 1'b0; bus.MEM_RDATA = 32'h0;
        test_reset();
        test_lw();
        test_load_extend();
        test_stores();
        test_misalign();
        test_non_mem();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule : tb_mem_access_ctrl
`default_nettype wire
